pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the fixed 64-bit ripple-carry adder chain.
- Splits the WIDTH-bit add into STAGES segments of SEG bits each. One segment is resolved per clock, and the carry is registered between stages.
- Single-cycle issue rate with a valid/ready handshake, so the integer datapath can close timing at higher clock rates.
- Sits between the operand-select logic and the result writeback of the ALU.

Parameters:
- WIDTH, 64, operand and result width in bits; must be a multiple of SEG.
- SEG, 16, bits resolved per pipeline stage; STAGES = WIDTH/SEG, with 1 <= STAGES <= 8.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-high
- in_valid  input  1  operands presented
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in; ignored when sub=1
- sub  input  1  1 = compute A-B, 0 = compute A+B+c_in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- c_out  output  1  raw carry out of the MSB (for subtract, 1 = no borrow)
- overflow  output  1  signed overflow
- zero  output  1  sum == 0

Behaviour:
- Reset:
  - While reset=1 at a clk edge, every stage valid bit clears.
  - Outputs settle to out_valid=0, sum=0, c_out=0, overflow=0, zero=0.
  - in_ready=1 in the first cycle after reset deasserts.
  - Reset during operation discards all in-flight operations; no partial results emerge.
- Advance condition:
  - advance = !out_valid || out_ready, and in_ready = advance (combinational).
  - The whole pipeline moves together when advance=1 and holds every register when advance=0.
- Accept: a transfer occurs when in_valid && in_ready.
  - Stage 0 captures a, the effective B (sub ? ~b : b), the effective carry (sub ? 1 : c_in), and valid=1.
  - It also computes segment 0.
  - If in_valid=0 while advance=1, a bubble (valid=0) enters.
- Stage k (1..STAGES-1):
  - Adds segment k of the carried operands with the registered carry from stage k-1.
  - Appends the result to the partial sum and forwards the still-unused upper operand bits.
  - Upper operand bits already consumed may be dropped.
- Latency:
  - An operation accepted at edge N appears with out_valid=1 after edge N+STAGES-1, so it is visible during cycle N+STAGES-1, provided no stall occurs.
  - Each stall cycle adds exactly one cycle. STAGES=1 gives a single registered output.
- Throughput: one operation per cycle with out_ready held at 1. Up to STAGES operations can be in flight. Bubbles are not compressed.
- Flags, registered with the final stage:
  - c_out is the carry out of bit WIDTH-1.
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero = (sum == 0).
- Hold rule: while out_valid=1 and out_ready=0, sum and all flags stay stable.
- Wrap-around: results are modulo 2^WIDTH; there is no saturation unless the optional feature is enabled.
- Simultaneous events:
  - An accept and a drain in the same cycle are legal and lose nothing.
  - reset has priority over everything.

Optional Feature:
- Macro: ADDER_SAT_EN.
- Defined:
  - Adds input port sat (1 bit), captured with the operands and carried through the pipeline.
  - When sat=1 and overflow=1, sum is clamped to 0x7FF..F on positive overflow or 0x800..0 on negative overflow.
  - Positive overflow is identified by the MSB of A being 0, after operand effective-B inversion.
  - overflow is still reported as 1, and zero is evaluated on the clamped sum.
  - Clamping is applied in the final stage and adds no latency.
- Undefined: the sat port is absent and results always wrap.

Test Plan (WIDTH=64, SEG=16, STAGES=4):
- Carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0, c_in=0 -> 4 cycles later sum=0, c_out=1, zero=1, overflow=0.
- Subtract and overflow:
  - a=0x8000_0000_0000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, overflow=1, c_out=1.
  - With ADDER_SAT_EN defined and sat=1 -> sum=0x8000_0000_0000_0000, overflow=1.
- Back-to-back issue: 8 consecutive operations (i, 2i) for i=1..8 with out_ready=1 -> results 3,6,...,24 on 8 consecutive cycles, starting at latency 4, in order.
- Backpressure:
  - Fill the pipeline, then drop out_ready for 5 cycles -> in_ready=0, and sum and flags are frozen throughout.
  - Release out_ready -> no loss or duplication of results.
- Reset mid-flight: issue 3 operations, assert reset for 1 cycle -> out_valid stays 0 until new operands are accepted, and none of the 3 results ever appear.
- Carry-in and bubbles: a=5, b=7, c_in=1, followed by a 2-cycle gap in in_valid, then a=0, b=0 -> first result sum=13, then out_valid low for exactly 2 cycles, then sum=0 with zero=1.

Source files
------------

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: one SEG-bit segment per stage, carry registered between stages.
// Optional ADDER_SAT_EN adds a 'sat' input that clamps overflowing results in the final stage.
module pipelined_addsub #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
`ifdef ADDER_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);
    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    function automatic logic [WIDTH-1:0] put_seg(input logic [WIDTH-1:0] s,
                                                 input logic [SEG-1:0]   v,
                                                 input int               k);
        logic [WIDTH-1:0] r;
        r = s;
        r[k*SEG +: SEG] = v;
        return r;
    endfunction

    logic                         advance;
    logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in, s_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
    logic [STAGES-1:0][SEG:0]     seg_w;
    logic [STAGES-1:0]            cy_in, v_in, sat_in, cy_d;
    logic [STAGES-1:0]            cy_q, v_q, sat_q;
    logic [WIDTH-1:0]             raw_sum, fin_sum;
    logic                         c_msb, cout_d, ovf_d, zero_d;
    logic                         cout_q, ovf_q, zero_q;
    logic                         unused_bits;

    assign advance  = !v_q[LAST] || out_ready;
    assign in_ready = advance;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign a_in[0]  = a;
                assign b_in[0]  = sub ? ~b : b;
                assign cy_in[0] = sub | c_in;
                assign v_in[0]  = in_valid;
                assign s_in[0]  = '0;
`ifdef ADDER_SAT_EN
                assign sat_in[0] = sat;
`else
                assign sat_in[0] = 1'b0;
`endif
            end else begin : g_body
                assign a_in[k]   = a_q[k-1];
                assign b_in[k]   = b_q[k-1];
                assign cy_in[k]  = cy_q[k-1];
                assign v_in[k]   = v_q[k-1];
                assign s_in[k]   = s_q[k-1];
                assign sat_in[k] = sat_q[k-1];
            end

            assign seg_w[k] = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
                            + {{SEG{1'b0}}, cy_in[k]};
            assign cy_d[k]  = seg_w[k][SEG];

            if (k == LAST) begin : g_tail
                assign s_d[k] = fin_sum;
            end else begin : g_mid
                assign s_d[k] = put_seg(s_in[k], seg_w[k][SEG-1:0], k);
            end
        end
    endgenerate

    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    assign raw_sum = put_seg(s_in[LAST], seg_w[LAST][SEG-1:0], LAST);
    assign c_msb   = seg_w[LAST][SEG-1] ^ a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1];
    assign cout_d  = seg_w[LAST][SEG];
    assign ovf_d   = c_msb ^ cout_d;

    always_comb begin
        fin_sum = raw_sum;
        if (sat_in[LAST] && ovf_d) begin
            fin_sum = a_in[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    assign zero_d = (fin_sum == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            cy_q   <= '0;
            v_q    <= '0;
            sat_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            a_q    <= a_in;
            b_q    <= b_in;
            s_q    <= s_d;
            cy_q   <= cy_d;
            v_q    <= v_in;
            sat_q  <= sat_in;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    // Final-stage operand copies feed nothing; synthesis trims them.
    assign unused_bits = ^{a_q[LAST], b_q[LAST], cy_q[LAST], sat_q[LAST]};

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign c_out     = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: arithmetic reference model over a STAGES-slot pipeline, directed and random traffic.
// Build with ADDER_SAT_EN defined to exercise the saturation port as well.
module tb_pipelined_addsub;
    localparam int WIDTH  = 64;
    localparam int SEG    = 16;
    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};

    logic             clk = 1'b0;
    logic             reset, in_valid, in_ready, c_in, sub;
    logic             out_valid, out_ready, c_out, overflow, zero;
    logic [WIDTH-1:0] a, b, sum;
    logic             sat_v;
    int               checks = 0;
    int               errors = 0;

`ifdef ADDER_SAT_EN
    logic sat;
    assign sat_v = sat;
`else
    assign sat_v = 1'b0;
`endif

    pipelined_addsub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
`ifdef ADDER_SAT_EN
        .sat(sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .c_out(c_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
        logic             z;
    } res_t;

    res_t mp[STAGES];

    // Whole-word arithmetic; overflow from operand/result signs.
    function automatic res_t calc(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic ci, input logic sb, input logic st);
        res_t             r;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] ye;
        ye   = sb ? ~y : y;
        full = {1'b0, x} + {1'b0, ye} + ((sb || ci) ? 1 : 0);
        r.v  = 1'b1;
        r.s  = full[WIDTH-1:0];
        r.co = full[WIDTH];
        r.ov = (x[WIDTH-1] == ye[WIDTH-1]) && (r.s[WIDTH-1] != x[WIDTH-1]);
        if (st && r.ov) r.s = x[WIDTH-1] ? MINV : MAXV;
        r.z = (r.s == 0);
        return r;
    endfunction

    function automatic res_t empty_slot();
        res_t r;
        r.v = 1'b0; r.s = '0; r.co = 1'b0; r.ov = 1'b0; r.z = 1'b0;
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) mp[i] = empty_slot();
        end else if (!mp[LAST].v || out_ready) begin
            for (int i = LAST; i > 0; i--) mp[i] = mp[i-1];
            mp[0] = in_valid ? calc(a, b, c_in, sub, sat_v) : empty_slot();
        end
    end

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        chk("m_in_ready", in_ready, !mp[LAST].v || out_ready);
        chk("m_out_valid", out_valid, mp[LAST].v);
        if (mp[LAST].v) begin
            chk("m_sum", sum, mp[LAST].s);
            chk("m_c_out", c_out, mp[LAST].co);
            chk("m_overflow", overflow, mp[LAST].ov);
            chk("m_zero", zero, mp[LAST].z);
        end
    end

    task automatic drive(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic ci, input logic sb);
        in_valid = v; a = x; b = y; c_in = ci; sub = sb;
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // One operation into an empty pipeline; checks exact latency and the result.
    task automatic op_check(input string nm, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic ci, input logic sb, input logic st,
                            input logic [WIDTH-1:0] es, input logic eco, input logic eov, input logic ez);
        drive(1'b1, x, y, ci, sb);
`ifdef ADDER_SAT_EN
        sat = st;
`endif
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (STAGES - 2) @(negedge clk);
        chk({nm, "_early"}, out_valid, 1'b0);
        @(negedge clk);
        chk({nm, "_valid"}, out_valid, 1'b1);
        chk({nm, "_sum"}, sum, es);
        chk({nm, "_cout"}, c_out, eco);
        chk({nm, "_ovf"}, overflow, eov);
        chk({nm, "_zero"}, zero, ez);
`ifdef ADDER_SAT_EN
        sat = 1'b0;
`endif
        idle(STAGES);
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return ONES;
            1:       return MINV;
            2:       return MAXV;
            3:       return WIDTH'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        res_t r;
        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
`ifdef ADDER_SAT_EN
        sat = 1'b0;
`endif
        // Pin the reference model against hand-computed results.
        r = calc(ONES, 1, 1'b0, 1'b0, 1'b0);
        chk("pin_ripple_sum", r.s, 0);
        chk("pin_ripple_co", r.co, 1'b1);
        r = calc(MINV, 1, 1'b0, 1'b1, 1'b0);
        chk("pin_sub_sum", r.s, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("pin_sub_ov", r.ov, 1'b1);
        r = calc(MINV, 1, 1'b0, 1'b1, 1'b1);
        chk("pin_sat_sum", r.s, 64'h8000_0000_0000_0000);
        r = calc(5, 7, 1'b1, 1'b0, 1'b0);
        chk("pin_cin_sum", r.s, 13);

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, '0);
        chk("rst_c_out", c_out, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_zero", zero, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);

        op_check("ripple", ONES, 1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        op_check("subovf", MINV, 1, 1'b0, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
`ifdef ADDER_SAT_EN
        op_check("satovf", MINV, 1, 1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
`endif

        // Back-to-back issue of (i, 2i), i = 1..8.
        for (int t = 0; t < 8 + STAGES; t++) begin
            if (t < 8) drive(1'b1, WIDTH'(t + 1), WIDTH'(2 * (t + 1)), 1'b0, 1'b0);
            else       drive(1'b0, '0, '0, 1'b0, 1'b0);
            @(negedge clk);
            if (t == LAST - 1) chk("b2b_early", out_valid, 1'b0);
            if (t >= LAST && t - LAST < 8) begin
                chk("b2b_valid", out_valid, 1'b1);
                chk("b2b_sum", sum, WIDTH'(3 * (t - LAST + 1)));
            end
        end
        idle(2);

        // Carry-in, 2-cycle gap, then a zero result.
        for (int t = 0; t < 4 + STAGES; t++) begin
            if (t == 0)      drive(1'b1, 5, 7, 1'b1, 1'b0);
            else if (t == 3) drive(1'b1, 0, 0, 1'b0, 1'b0);
            else             drive(1'b0, '0, '0, 1'b0, 1'b0);
            @(negedge clk);
            if (t == LAST) begin
                chk("gap_first_valid", out_valid, 1'b1);
                chk("gap_first_sum", sum, 13);
            end
            if (t == LAST + 1 || t == LAST + 2) chk("gap_bubble", out_valid, 1'b0);
            if (t == LAST + 3) begin
                chk("gap_last_valid", out_valid, 1'b1);
                chk("gap_last_sum", sum, 0);
                chk("gap_last_zero", zero, 1'b1);
            end
        end
        idle(2);

        // Backpressure: fill, stall 5 cycles with an operation pending, release.
        for (int t = 0; t < STAGES; t++) begin
            drive(1'b1, WIDTH'((t + 1) * 100), WIDTH'(t + 1), 1'b0, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b0;
        drive(1'b1, 500, 5, 1'b0, 1'b0);
        for (int t = 0; t < 5; t++) begin
            #1;
            chk("bp_in_ready", in_ready, 1'b0);
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_sum", sum, 101);
            chk("bp_hold_cout", c_out, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_sum", sum, 202);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int j = 3; j <= 5; j++) begin
            @(negedge clk);
            chk("bp_rel_sum", sum, WIDTH'(j * 101));
        end
        @(negedge clk);
        chk("bp_drained", out_valid, 1'b0);
        idle(2);

        // Reset with three operations in flight.
        for (int t = 0; t < 3; t++) begin
            drive(1'b1, pick(), pick(), 1'($urandom), 1'($urandom));
            @(negedge clk);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < STAGES + 2; j++) begin
            chk("midrst_quiet", out_valid, 1'b0);
            @(negedge clk);
        end

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 9) < 7), pick(), pick(), 1'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 99) == 0);
`ifdef ADDER_SAT_EN
            sat = 1'($urandom);
`endif
            @(negedge clk);
        end
        reset = 1'b0;
        idle(STAGES + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
